// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the frame-buffer arbiter.
// Optional build macro FB_ARB_STATS_EN is consumed by fb_arbiter.
package fb_pkg;

   localparam int unsigned IMG_W_DEF = 320;
   localparam int unsigned IMG_H_DEF = 240;
   localparam int unsigned FB_DEPTH  = 76800;
   localparam int unsigned FB_AW     = 17;
   localparam int unsigned FB_DW     = 16;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StWrite = 2'd2
   } fb_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Read address for a 2x upscaled frame: (v_cnt>>1)*IMG_W + (h_cnt>>1).
module fb_addr_gen
   import fb_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF
) (
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   output logic [FB_AW-1:0] rd_addr
);

   localparam logic [FB_AW-1:0] RowLen = FB_AW'(IMG_W);

   always_comb begin
      rd_addr = FB_AW'(v_cnt >> 1) * RowLen + FB_AW'(h_cnt >> 1);
   end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame RAM arbiter: VGA reads on every even visible pixel, writer gets the rest.
// Define FB_ARB_STATS_EN to build the saturating writer stall counter.
module fb_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   input  logic [9:0]       h_cnt,
   input  logic [9:0]       v_cnt,
   input  logic             visible,
   input  logic             wr_req,
   input  logic [FB_AW-1:0] wr_addr,
   input  logic [FB_DW-1:0] wr_data,
   output logic             wr_ack,
   output logic             wr_err,
   output logic [FB_AW-1:0] ram_addr,
   output logic             ram_we,
   output logic [FB_DW-1:0] ram_wdata,
   input  logic [FB_DW-1:0] ram_rdata,
   output logic [FB_DW-1:0] pixel_data,
   output logic [15:0]      stall_cnt
);

   localparam logic [FB_AW-1:0] Depth = FB_AW'(IMG_W * IMG_H);

   logic [FB_AW-1:0] rd_addr;
   logic             rd_slot;
   logic             addr_oob;
   logic             ack_q;
   logic [FB_DW-1:0] pixel_q;
   fb_state_e        state_d, state_q;

   fb_addr_gen #(
      .IMG_W(IMG_W)
   ) u_addr_gen (
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .rd_addr(rd_addr)
   );

   assign rd_slot  = visible & ~h_cnt[0];
   assign addr_oob = (wr_addr >= Depth);

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= wr_ack;
      end
   end

   // Slots are only known from the live counters, so the state is decided in the cycle it
   // applies; state_q records the previous cycle's state for the read-data capture.
   always_comb begin
      state_d = StIdle;
      if (!rst) begin
         state_d = StIdle;
      end else if (rd_slot) begin
         state_d = StRead;
      end else if (wr_req && !ack_q) begin
         state_d = StWrite;
      end
   end

   always_comb begin
      wr_ack    = 1'b0;
      wr_err    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      unique case (state_d)
         StRead: begin
            ram_addr = rd_addr;
         end
         StWrite: begin
            wr_ack    = 1'b1;
            wr_err    = addr_oob;
            ram_we    = ~addr_oob;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
         end
         default: begin
         end
      endcase
   end

   // RAM data is valid the cycle after the READ address.
   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         pixel_q <= '0;
      end else if (state_q == StRead) begin
         pixel_q <= ram_rdata;
      end
   end

   assign pixel_data = pixel_q;

`ifdef FB_ARB_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk_50mhz or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else if (rd_slot && wr_req && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with hand-computed expectations.
module tb_fb_arbiter;

   logic        clk_50mhz = 1'b0;
   logic        rst;
   logic [9:0]  h_cnt, v_cnt;
   logic        visible, wr_req;
   logic [16:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack, wr_err, ram_we;
   logic [16:0] ram_addr;
   logic [15:0] ram_wdata, ram_rdata, pixel_data, stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

`ifdef FB_ARB_STATS_EN
   localparam logic [15:0] StallExp = 16'd1;
`else
   localparam logic [15:0] StallExp = 16'd0;
`endif

   always #5 clk_50mhz = ~clk_50mhz;

   fb_arbiter dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .visible   (visible),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .wr_err    (wr_err),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .pixel_data(pixel_data),
      .stall_cnt (stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_50mhz);
      #1;
   endtask

   initial begin
      rst = 1'b0; h_cnt = '0; v_cnt = '0; visible = 1'b0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0; ram_rdata = '0;
      #2;
      check_eq("rst_we", 32'(ram_we), 0);
      check_eq("rst_addr", 32'(ram_addr), 0);
      check_eq("rst_wdata", 32'(ram_wdata), 0);
      check_eq("rst_ack", 32'(wr_ack), 0);
      check_eq("rst_err", 32'(wr_err), 0);
      check_eq("rst_pix", 32'(pixel_data), 0);
      check_eq("rst_stall", 32'(stall_cnt), 0);
      wr_req = 1'b1; wr_addr = 17'd5; #1;
      check_eq("rst_req_ack", 32'(wr_ack), 0);
      check_eq("rst_req_we", 32'(ram_we), 0);
      wr_req = 1'b0;
      step; rst = 1'b1;
      step;

      // First read slot, pixel appears two cycles later
      visible = 1'b1; h_cnt = 10'd0; v_cnt = 10'd0; #1;
      check_eq("slot0_we", 32'(ram_we), 0);
      check_eq("slot0_addr", 32'(ram_addr), 0);
      check_eq("slot0_ack", 32'(wr_ack), 0);
      step; visible = 1'b0; ram_rdata = 16'hF800; #1;
      check_eq("pix_lat1", 32'(pixel_data), 0);
      step; ram_rdata = 16'h1234; #1;
      check_eq("pix_lat2", 32'(pixel_data), 32'hF800);
      step; #1;
      check_eq("pix_hold", 32'(pixel_data), 32'hF800);

      // Address generation corners
      visible = 1'b1; h_cnt = 10'd638; v_cnt = 10'd479; #1;
      check_eq("addr_last", 32'(ram_addr), 76799);
      check_eq("addr_last_we", 32'(ram_we), 0);
      step; h_cnt = 10'd100; v_cnt = 10'd50; #1;
      check_eq("addr_mid", 32'(ram_addr), 8050);
      step; h_cnt = 10'd3; #1;
      check_eq("odd_idle_addr", 32'(ram_addr), 0);
      check_eq("odd_idle_we", 32'(ram_we), 0);
      step; visible = 1'b0; ram_rdata = 16'h0000;
      step;

      // Blanking write, then held request needs one idle cycle
      wr_req = 1'b1; wr_addr = 17'd100; wr_data = 16'h07E0; #1;
      check_eq("wr_we", 32'(ram_we), 1);
      check_eq("wr_addr", 32'(ram_addr), 100);
      check_eq("wr_wdata", 32'(ram_wdata), 32'h07E0);
      check_eq("wr_ack", 32'(wr_ack), 1);
      check_eq("wr_err", 32'(wr_err), 0);
      step; #1;
      check_eq("gap_ack", 32'(wr_ack), 0);
      check_eq("gap_we", 32'(ram_we), 0);
      step; #1;
      check_eq("rewr_ack", 32'(wr_ack), 1);
      step; wr_req = 1'b0;
      step;

      // Collision: read wins, write lands on next non-slot cycle
      visible = 1'b1; h_cnt = 10'd2; v_cnt = 10'd0;
      wr_req = 1'b1; wr_addr = 17'd200; wr_data = 16'hABCD; #1;
      check_eq("col_ack", 32'(wr_ack), 0);
      check_eq("col_we", 32'(ram_we), 0);
      check_eq("col_addr", 32'(ram_addr), 1);
      step; h_cnt = 10'd3; #1;
      check_eq("def_ack", 32'(wr_ack), 1);
      check_eq("def_we", 32'(ram_we), 1);
      check_eq("def_addr", 32'(ram_addr), 200);
      step; wr_req = 1'b0; visible = 1'b0; #1;
      check_eq("stall", 32'(stall_cnt), 32'(StallExp));
      step;

      // Out-of-range write is acked and flagged but not written
      wr_req = 1'b1; wr_addr = 17'd76800; wr_data = 16'h5555; #1;
      check_eq("oob_ack", 32'(wr_ack), 1);
      check_eq("oob_err", 32'(wr_err), 1);
      check_eq("oob_we", 32'(ram_we), 0);
      step; wr_req = 1'b0;
      step;

      // Reset during a write aborts it; held request is served after release
      wr_req = 1'b1; wr_addr = 17'd300; wr_data = 16'h1111; #1;
      check_eq("pre_rst_ack", 32'(wr_ack), 1);
      rst = 1'b0; #1;
      check_eq("mid_rst_ack", 32'(wr_ack), 0);
      check_eq("mid_rst_we", 32'(ram_we), 0);
      check_eq("mid_rst_addr", 32'(ram_addr), 0);
      check_eq("mid_rst_wdata", 32'(ram_wdata), 0);
      check_eq("mid_rst_pix", 32'(pixel_data), 0);
      check_eq("mid_rst_stall", 32'(stall_cnt), 0);
      step;
      step; rst = 1'b1; #1;
      check_eq("post_rst_ack", 32'(wr_ack), 1);
      check_eq("post_rst_addr", 32'(ram_addr), 300);
      check_eq("post_rst_we", 32'(ram_we), 1);
      step; #1;
      check_eq("post_rst_gap", 32'(wr_ack), 0);
      wr_req = 1'b0;
      step;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
